// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: takes host words over valid/ready and shifts them MSB-first into one ccff chain.
// Define CCFF_READBACK_EN to add a recirculating verify pass that sets a sticky error flag on readback mismatch.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_SHIFT,
`ifdef CCFF_READBACK_EN
        S_VERIFY,
`endif
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  sreg_q, sreg_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   first_cnt;
    logic               word_ready_q, word_ready_d;
    logic               head_q, head_d;
    logic               clk_en_q, clk_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef CCFF_READBACK_EN
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic                 error_q, error_d;
`endif

    // Bits to take from the word being accepted: a full word, or whatever is left of the chain.
    always_comb begin
        if (32'(remaining_q) >= 32'(WORD_W)) first_cnt = CNT_W'(WORD_W);
        else                                 first_cnt = remaining_q;
    end

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        remaining_d  = remaining_q;
        bit_cnt_d    = bit_cnt_q;
        word_ready_d = 1'b0;
        head_d       = head_q;
        clk_en_d     = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef CCFF_READBACK_EN
        shadow_d     = shadow_q;
        error_d      = error_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_WAIT_WORD;
                    busy_d       = 1'b1;
                    word_ready_d = 1'b1;
                    remaining_d  = CNT_W'(CHAIN_LEN);
`ifdef CCFF_READBACK_EN
                    error_d      = 1'b0;
`endif
                end
            end
            S_WAIT_WORD: begin
                word_ready_d = 1'b1;
                if (word_valid && word_ready_q) begin
                    state_d      = S_SHIFT;
                    word_ready_d = 1'b0;
                    head_d       = word_in[WORD_W-1];
                    sreg_d       = word_in << 1;
                    clk_en_d     = 1'b1;
                    bit_cnt_d    = first_cnt;
                end
            end
            S_SHIFT: begin
                // remaining counts the bit currently on ccff_head, so the chain is full when it reads 1.
                remaining_d = remaining_q - CNT_W'(1);
                bit_cnt_d   = bit_cnt_q - CNT_W'(1);
`ifdef CCFF_READBACK_EN
                shadow_d    = (shadow_q << 1) | CHAIN_LEN'(head_q);
`endif
                if (remaining_q == CNT_W'(1)) begin
`ifdef CCFF_READBACK_EN
                    state_d     = S_VERIFY;
                    clk_en_d    = 1'b1;
                    remaining_d = CNT_W'(CHAIN_LEN);
`else
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
`endif
                end else if (bit_cnt_q == CNT_W'(1)) begin
                    state_d      = S_WAIT_WORD;
                    word_ready_d = 1'b1;
                end else begin
                    clk_en_d = 1'b1;
                    head_d   = sreg_q[WORD_W-1];
                    sreg_d   = sreg_q << 1;
                end
            end
`ifdef CCFF_READBACK_EN
            S_VERIFY: begin
                head_d      = ccff_tail;
                remaining_d = remaining_q - CNT_W'(1);
                shadow_d    = (shadow_q << 1) | CHAIN_LEN'(shadow_q[CHAIN_LEN-1]);
                if (ccff_tail != shadow_q[CHAIN_LEN-1]) error_d = 1'b1;
                if (remaining_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    clk_en_d = 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q      <= S_IDLE;
            sreg_q       <= '0;
            remaining_q  <= '0;
            bit_cnt_q    <= '0;
            word_ready_q <= 1'b0;
            head_q       <= 1'b0;
            clk_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CCFF_READBACK_EN
            shadow_q     <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            remaining_q  <= remaining_d;
            bit_cnt_q    <= bit_cnt_d;
            word_ready_q <= word_ready_d;
            head_q       <= head_d;
            clk_en_q     <= clk_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef CCFF_READBACK_EN
            shadow_q     <= shadow_d;
            error_q      <= error_d;
`endif
        end
    end

    assign word_ready   = word_ready_q;
    assign chain_clk_en = clk_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
`ifdef CCFF_READBACK_EN
    // Recirculation needs the tail bit in the same cycle, so VERIFY bypasses the head register.
    assign ccff_head = (state_q == S_VERIFY) ? ccff_tail : head_q;
    assign error     = error_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign ccff_head   = head_q;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a 32-bit and a 30-bit instance, each driving a bench shift-register chain.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

    localparam int WW   = 8;
    localparam int LEN0 = 32;
    localparam int LEN1 = 30;
`ifdef CCFF_READBACK_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    typedef struct {
        logic [31:0] chain;
        logic        chk_chain;
        int          shifts;
        int          words;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst_w, start_w, valid_w, ready_w, head_w, en_w, tail_w, busy_w, done_w, error_w;
    logic [WW-1:0] word_w [2];
    logic [31:0]   chain_r [2] = '{32'h0, 32'h0};
    logic [1:0]    fault_arm;
    int            shifts_seen [2] = '{0, 0};
    int            words_seen  [2] = '{0, 0};
    int            viol_seen   [2] = '{0, 0};
    exp_t          q0[$], q1[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    ccff_chain_loader #(.CHAIN_LEN(LEN0), .WORD_W(WW)) u_dut0 (
        .prog_clk(clk), .prog_reset(rst_w[0]), .start(start_w[0]), .word_in(word_w[0]),
        .word_valid(valid_w[0]), .word_ready(ready_w[0]), .ccff_head(head_w[0]),
        .chain_clk_en(en_w[0]), .ccff_tail(tail_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .error(error_w[0])
    );

    ccff_chain_loader #(.CHAIN_LEN(LEN1), .WORD_W(WW)) u_dut1 (
        .prog_clk(clk), .prog_reset(rst_w[1]), .start(start_w[1]), .word_in(word_w[1]),
        .word_valid(valid_w[1]), .word_ready(ready_w[1]), .ccff_head(head_w[1]),
        .chain_clk_en(en_w[1]), .ccff_tail(tail_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .error(error_w[1])
    );

    // Bench chains: bit 0 is the head end, bit LEN-1 the tail. Optional single bit-9 upset during VERIFY.
    assign tail_w[0] = chain_r[0][LEN0-1];
    assign tail_w[1] = chain_r[1][LEN1-1];
    always @(posedge clk) begin
        if (en_w[0])
            chain_r[0] <= {chain_r[0][30:0], head_w[0]} ^
                          ((fault_arm[0] && shifts_seen[0] == LEN0 + 2) ? 32'h200 : 32'h0);
        if (en_w[1])
            chain_r[1] <= {chain_r[1][30:0], head_w[1]} ^
                          ((fault_arm[1] && shifts_seen[1] == LEN1 + 2) ? 32'h200 : 32'h0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] outs(input int sel);
        return {ready_w[sel], head_w[sel], en_w[sel], busy_w[sel], done_w[sel], error_w[sel]};
    endfunction

    // Reference: the chain ends up holding the first LEN bits of the word stream, first bit at the tail.
    function automatic logic [31:0] model_chain(input int len, input logic [7:0] w [4]);
        logic [31:0] stream;
        stream = {w[0], w[1], w[2], w[3]};
        return stream >> (32 - len);
    endfunction

    task automatic on_done(input int i);
        exp_t        e;
        logic        have;
        logic [31:0] mask;
        have = 1'b0;
        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        check($sformatf("done_expected%0d", i), have, 1'b1);
        if (!have) return;
        mask = (i == 0) ? 32'hFFFF_FFFF : 32'h3FFF_FFFF;
        if (e.chk_chain) check($sformatf("chain%0d", i), chain_r[i] & mask, e.chain & mask);
        check($sformatf("shifts%0d", i), shifts_seen[i], e.shifts);
        check($sformatf("words%0d", i), words_seen[i], e.words);
        check($sformatf("en_outside_shift%0d", i), viol_seen[i], 0);
        check($sformatf("error_at_done%0d", i), error_w[i], e.err);
        check($sformatf("busy_at_done%0d", i), busy_w[i], 1'b0);
    endtask

    // Monitor: counts chain clocks, accepted words and illegal chain clocks; checks on every done pulse.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst_w[i]) begin
                    shifts_seen[i] = 0; words_seen[i] = 0; viol_seen[i] = 0;
                end else begin
                    if (en_w[i]) shifts_seen[i]++;
                    if (valid_w[i] && ready_w[i]) words_seen[i]++;
                    if (en_w[i] && (ready_w[i] || !busy_w[i])) viol_seen[i]++;
                    if (done_w[i]) begin
                        on_done(i);
                        shifts_seen[i] = 0; words_seen[i] = 0; viol_seen[i] = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int sel, input logic exp_err);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = !busy_w[sel] && !done_w[sel];
        end
        check("load_completes", ok, 1'b1);
        repeat (3) @(negedge clk);
        check("error_after_done", error_w[sel], exp_err);
    endtask

    task automatic run_load(input int sel, input logic [7:0] w [4], input int g [4],
                            input int abort_word, input logic start_mid, input logic fault);
        exp_t e;
        int   len;
        logic got;
        len         = (sel == 0) ? LEN0 : LEN1;
        e.chain     = model_chain(len, w);
        e.chk_chain = !fault;
        e.shifts    = PASSES * len;
        e.words     = (len + WW - 1) / WW;
        e.err       = fault;
        if (abort_word < 0) begin
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        @(posedge clk); #1 start_w[sel] = 1'b1; fault_arm[sel] = fault;
        @(posedge clk); #1 start_w[sel] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (g[k]) begin
                word_w[sel] = 8'($urandom);
                @(posedge clk); #1;
            end
            word_w[sel]  = w[k];
            valid_w[sel] = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge clk);
                got = ready_w[sel];
            end
            check("word_accepted", got, 1'b1);
            @(posedge clk); #1 valid_w[sel] = 1'b0; word_w[sel] = 8'($urandom);
            if (!got) return;
            if (k == abort_word) begin
                repeat (4) begin @(posedge clk); #1; end
                rst_w[sel] = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("abort_outputs", outs(sel), 6'b0);
                #1 rst_w[sel] = 1'b0;
                return;
            end
            if (k == 0 && start_mid) begin
                start_w[sel] = 1'b1;
                @(posedge clk); #1 start_w[sel] = 1'b0;
            end
        end
        wait_idle(sel, fault);
    endtask

    initial begin
        logic [7:0] w [4];
        int         g [4];
        start_w = '0; valid_w = '0; rst_w = '1; fault_arm = '0;
        word_w[0] = '0; word_w[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset0", outs(0), 6'b0);
        check("reset1", outs(1), 6'b0);
        @(posedge clk); #1 rst_w = '0;

        w = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        g = '{0, 0, 0, 0};
        run_load(0, w, g, -1, 1'b0, 1'b0);
        g = '{0, 0, 3, 7};
        run_load(0, w, g, -1, 1'b0, 1'b0);
        w[3] = 8'h03;
        g = '{0, 0, 0, 0};
        run_load(1, w, g, -1, 1'b0, 1'b0);
        w[3] = 8'h01;
        run_load(0, w, g, 1, 1'b0, 1'b0);
        run_load(0, w, g, -1, 1'b0, 1'b0);
        run_load(0, w, g, -1, 1'b1, 1'b0);

        @(posedge clk); #1 start_w[1] = 1'b1; rst_w[1] = 1'b1;
        @(posedge clk); #1 start_w[1] = 1'b0; rst_w[1] = 1'b0;
        @(negedge clk);
        check("start_vs_reset", outs(1), 6'b0);

`ifdef CCFF_READBACK_EN
        run_load(0, w, g, -1, 1'b0, 1'b1);
        run_load(0, w, g, -1, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 24; n++) begin
            int sel;
            sel = int'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                w[k] = 8'($urandom);
                g[k] = int'($urandom_range(0, 7));
            end
            run_load(sel, w, g, -1, ($urandom_range(0, 3) == 0), 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
